// File: rtl/cpu_trace_monitor.sv
// cpu_trace_monitor: records retired register writes, loads, stores and the final halt
// into a show-ahead trace FIFO, with drop, instruction and cycle counters.
module cpu_trace_monitor #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int REG_W      = 4,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     reg_we,
  input  logic [REG_W-1:0]         reg_dst,
  input  logic [DATA_W-1:0]        reg_data,
  input  logic                     mem_en,
  input  logic                     mem_wr,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     halt,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [1:0]               rd_kind,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count,
  output logic [CNT_W-1:0]         inst_count,
  output logic [CNT_W-1:0]         cycle_count,
  output logic                     done,
  output logic                     timeout
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;
  state_t state;
  logic [1:0]        kindMem [DEPTH];
  logic [ADDR_W-1:0] addrMem [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];
  logic [PW-1:0]     wrPtr, rdPtr, wrPtrNext;
  logic [1:0]        nEv, kind0, memKind;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] data0, memData;
  logic              running, flushing, drop, push, pop, instInc;
  logic [PW:0]       freeSpace, pushCnt;
  logic [CNT_W:0]    dropSum;

  // The first slot holds REG (or the lone memory event, or HALT); the second is always memory.
  always_comb begin
    running   = state == RUN;
    flushing  = state == FLUSH;
    nEv       = running ? 2'(reg_we) + 2'(mem_en) : {1'b0, flushing};
    memKind   = mem_wr ? 2'b10 : 2'b01;
    memData   = mem_wr ? mem_wdata : mem_rdata;
    kind0     = flushing ? 2'b11 : reg_we ? 2'b00 : memKind;
    addr0     = flushing ? '0 : reg_we ? ADDR_W'(reg_dst) : mem_addr;
    data0     = flushing ? DATA_W'(inst_count) : reg_we ? reg_data : memData;
    freeSpace = (PW+1)'(DEPTH) - fill;
    drop      = (PW+1)'(nEv) > freeSpace;
    push      = nEv != 2'd0 && !drop;
    pushCnt   = push ? (PW+1)'(nEv) : '0;
    pop       = rd_valid && rd_ready;
    wrPtrNext = wrPtr + 1'b1;
    dropSum   = {1'b0, drop_count} + (CNT_W+1)'(nEv);
    instInc   = running && (reg_we || (mem_en && mem_wr) || halt);
  end

  assign rd_valid = fill != '0;
  assign rd_kind  = rd_valid ? kindMem[rdPtr] : '0;
  assign rd_addr  = rd_valid ? addrMem[rdPtr] : '0;
  assign rd_data  = rd_valid ? dataMem[rdPtr] : '0;

  always_ff @(posedge clk) begin
    if (push && !clear && !rst) begin
      kindMem[wrPtr] <= kind0;
      addrMem[wrPtr] <= addr0;
      dataMem[wrPtr] <= data0;
      if (nEv == 2'd2) begin
        kindMem[wrPtrNext] <= memKind;
        addrMem[wrPtrNext] <= mem_addr;
        dataMem[wrPtrNext] <= memData;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      wrPtr       <= '0;
      rdPtr       <= '0;
      fill        <= '0;
      overflow    <= 1'b0;
      drop_count  <= '0;
      inst_count  <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else if (clear) begin
      state       <= RUN;
      wrPtr       <= '0;
      rdPtr       <= '0;
      fill        <= '0;
      overflow    <= 1'b0;
      drop_count  <= '0;
      inst_count  <= '0;
      cycle_count <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(nEv);
      if (pop) rdPtr <= rdPtr + 1'b1;
      fill <= fill + pushCnt - (PW+1)'(pop);
      if (drop) begin
        overflow   <= 1'b1;
        drop_count <= dropSum[CNT_W] ? '1 : dropSum[CNT_W-1:0];
      end
      if (instInc && inst_count != '1) inst_count <= inst_count + 1'b1;
      if ((running || flushing) && cycle_count != '1) cycle_count <= cycle_count + 1'b1;
      if (running && halt) state <= FLUSH;
      else if (running && cycle_count == CNT_W'(MAX_CYCLES - 1)) begin
        state   <= DONE;
        timeout <= 1'b1;
        done    <= 1'b1;
      end else if (flushing) begin
        state <= DONE;
        done  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cpu_trace_monitor.sv
// tb_cpu_trace_monitor: directed scenarios plus random traffic checked against a queue-based model.
module tb_cpu_trace_monitor;
  localparam int DEPTH = 16;
  localparam int MAXC  = 64;
  localparam longint SAT = 64'hFFFF_FFFF;

  logic        clk = 1'b0, rst = 1'b1, clear = 1'b0;
  logic        reg_we = 1'b0, mem_en = 1'b0, mem_wr = 1'b0, halt = 1'b0, rd_ready = 1'b0;
  logic [3:0]  reg_dst = '0;
  logic [15:0] reg_data = '0, mem_addr = '0, mem_wdata = '0, mem_rdata = '0;
  logic        rd_valid, overflow, done, timeout;
  logic [1:0]  rd_kind;
  logic [15:0] rd_addr, rd_data;
  logic [4:0]  fill;
  logic [31:0] drop_count, inst_count, cycle_count;

  int nChecks = 0, nFail = 0;
  logic [33:0] q[$];
  int phase;
  longint mInst, mCyc, mDrop;
  bit mOvf, mTo, mDone;
  logic [31:0] frozen;

  always #5 clk = ~clk;

  cpu_trace_monitor #(.DATA_W(16), .ADDR_W(16), .REG_W(4), .DEPTH(DEPTH), .CNT_W(32),
                      .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst), .clear(clear), .reg_we(reg_we), .reg_dst(reg_dst),
    .reg_data(reg_data), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .halt(halt), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_kind(rd_kind), .rd_addr(rd_addr), .rd_data(rd_data),
    .fill(fill), .overflow(overflow), .drop_count(drop_count), .inst_count(inst_count),
    .cycle_count(cycle_count), .done(done), .timeout(timeout));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    q.delete();
    phase = 0;
    mInst = 0; mCyc = 0; mDrop = 0;
    mOvf = 0; mTo = 0; mDone = 0;
  endtask

  // One clock of the trace monitor described as a list of events appended to a queue.
  task automatic modelCycle();
    logic [33:0] ev[$];
    bit popNow;
    longint oldCyc;
    if (clear) begin
      modelReset();
      return;
    end
    if (phase == 0) begin
      if (reg_we) ev.push_back({2'b00, 12'h000, reg_dst, reg_data});
      if (mem_en) ev.push_back(mem_wr ? {2'b10, mem_addr, mem_wdata} : {2'b01, mem_addr, mem_rdata});
    end else if (phase == 1) ev.push_back({2'b11, 16'h0000, mInst[15:0]});
    popNow = q.size() != 0 && rd_ready;
    if (ev.size() > DEPTH - q.size()) begin
      mOvf = 1;
      mDrop = (mDrop + ev.size() > SAT) ? SAT : mDrop + ev.size();
    end else foreach (ev[i]) q.push_back(ev[i]);
    if (popNow) void'(q.pop_front());
    oldCyc = mCyc;
    if (phase == 0 && (reg_we || (mem_en && mem_wr) || halt) && mInst < SAT) mInst++;
    if (phase != 2 && mCyc < SAT) mCyc++;
    if (phase == 0 && halt) phase = 1;
    else if (phase == 0 && oldCyc == MAXC - 1) begin
      phase = 2; mTo = 1; mDone = 1;
    end else if (phase == 1) begin
      phase = 2; mDone = 1;
    end
  endtask

  task automatic compare();
    logic [33:0] h;
    h = (q.size() != 0) ? q[0] : '0;
    chk("fill", fill, q.size());
    chk("rd_valid", rd_valid, q.size() != 0);
    chk("head", {rd_kind, rd_addr, rd_data}, h);
    chk("overflow", overflow, mOvf);
    chk("drop_count", drop_count, mDrop);
    chk("inst_count", inst_count, mInst);
    chk("cycle_count", cycle_count, mCyc);
    chk("done", done, mDone);
    chk("timeout", timeout, mTo);
  endtask

  task automatic step();
    modelCycle();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle();
    reg_we = 0; mem_en = 0; mem_wr = 0; halt = 0; rd_ready = 0; clear = 0;
  endtask

  task automatic doClear();
    idle();
    clear = 1;
    step();
    clear = 0;
  endtask

  task automatic rnd(input bit allowHalt);
    reg_we    = 1'($urandom);
    reg_dst   = 4'($urandom);
    reg_data  = 16'($urandom);
    mem_en    = 1'($urandom);
    mem_wr    = 1'($urandom);
    mem_addr  = 16'($urandom);
    mem_wdata = 16'($urandom);
    mem_rdata = 16'($urandom);
    rd_ready  = ($urandom_range(0, 3) != 0);
    halt      = allowHalt && ($urandom_range(0, 40) == 0);
  endtask

  initial begin
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    compare();
    chk("reset_fill", fill, 0);
    chk("reset_head", {rd_kind, rd_addr, rd_data}, 0);
    rst = 0;

    // register write and store in one cycle
    reg_we = 1; reg_dst = 4'd3; reg_data = 16'h1234;
    mem_en = 1; mem_wr = 1; mem_addr = 16'h0040; mem_wdata = 16'hBEEF;
    step();
    idle();
    chk("pair_fill", fill, 2);
    chk("pair_head0", {rd_kind, rd_addr, rd_data}, {2'b00, 16'h0003, 16'h1234});
    chk("pair_inst", inst_count, 1);
    rd_ready = 1;
    step();
    chk("pair_head1", {rd_kind, rd_addr, rd_data}, {2'b10, 16'h0040, 16'hBEEF});
    step();
    idle();

    for (int i = 0; i < 300; i++) begin
      rnd(0);
      step();
    end

    // atomic drop on a nearly full FIFO
    doClear();
    for (int i = 0; i < 15; i++) begin
      reg_we = 1; reg_data = 16'(i);
      step();
    end
    chk("fill15", fill, 15);
    mem_en = 1; mem_wr = 0; mem_rdata = 16'h5A5A;
    step();
    chk("drop2_fill", fill, 15);
    chk("drop2_ovf", overflow, 1);
    chk("drop2_cnt", drop_count, 2);
    mem_en = 0;
    step();
    chk("fill16", fill, 16);
    rd_ready = 1;
    step();
    chk("full_pop_fill", fill, 15);
    chk("full_pop_drop", drop_count, 3);
    rd_ready = 0;
    step();
    chk("refill16", fill, 16);

    // halt after five instructions
    doClear();
    for (int i = 0; i < 5; i++) begin
      reg_we = 1; reg_dst = 4'(i); reg_data = 16'(100 + i);
      step();
    end
    idle();
    halt = 1;
    step();
    chk("halt_done_early", done, 0);
    halt = 0;
    step();
    chk("halt_done", done, 1);
    chk("halt_fill", fill, 6);
    frozen = cycle_count;
    reg_we = 1; mem_en = 1; mem_wr = 1;
    repeat (3) step();
    chk("halt_frozen", cycle_count, frozen);
    chk("halt_ignored", fill, 6);
    idle();
    rd_ready = 1;
    repeat (5) step();
    chk("halt_entry", {rd_kind, rd_addr, rd_data}, {2'b11, 16'h0000, 16'h0006});
    step();

    // timeout without halt
    doClear();
    for (int i = 0; i < MAXC; i++) begin
      rnd(0);
      step();
    end
    chk("to_timeout", timeout, 1);
    chk("to_cycles", cycle_count, MAXC);
    idle();
    rd_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      chk("to_no_halt", rd_valid && rd_kind == 2'b11, 0);
    end

    // asynchronous reset while in FLUSH with entries queued
    doClear();
    for (int i = 0; i < 7; i++) begin
      reg_we = 1; reg_data = 16'(i); halt = (i == 6);
      step();
    end
    idle();
    chk("pre_rst_fill", fill, 7);
    #2 rst = 1;
    #1;
    chk("rst_fill", fill, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_head", {rd_kind, rd_addr, rd_data}, 0);
    chk("rst_inst", inst_count, 0);
    chk("rst_flags", {done, timeout, overflow}, 0);
    modelReset();
    @(posedge clk);
    #1;
    rst = 0;
    reg_we = 1; reg_dst = 4'hA; reg_data = 16'hCAFE;
    step();
    chk("post_rst_head", {rd_kind, rd_addr, rd_data}, {2'b00, 16'h000A, 16'hCAFE});
    idle();

    for (int i = 0; i < 400; i++) begin
      if (phase == 2 && $urandom_range(0, 9) == 0) doClear();
      rnd(1);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
